// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator stimulus engine and its display consumer.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    UP    = 2'b01,
    DOWN  = 2'b10,
    DOORS = 2'b11
  } sim_state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Upper bound on FLOORS supported by the pending-mask helpers.
  localparam int MAX_FLOORS = 32;

  function automatic logic pending_above(input logic [MAX_FLOORS-1:0] mask, input int floor);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if (i > floor) hit = hit | mask[i];
    end
    return hit;
  endfunction

  function automatic logic pending_below(input logic [MAX_FLOORS-1:0] mask, input int floor);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if (i < floor) hit = hit | mask[i];
    end
    return hit;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider; tick is high during the cycle the count wraps DIV-1 -> 0.
module tick_prescaler #(
  parameter int DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(DIV - 1));
  assign tick   = en && w_wrap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/elevator_sim_driver.sv
// Simulated elevator car: accepts floor requests, moves one floor per tick with SCAN
// ordering, and optionally reloads a demo request pattern whenever the car goes idle.
module elevator_sim_driver #(
  parameter int          FLOORS       = 8,
  parameter int          TICK_DIV     = 25_000_000,
  parameter int          DOOR_TICKS   = 3,
  parameter logic [31:0] DEMO_PATTERN = 32'b1010_1010,
  localparam int         FW           = $clog2(FLOORS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              demo_mode,
  input  logic              req_valid,
  input  logic [FW-1:0]     req_floor,
  output logic              req_ready,
  output logic              req_err,
  output logic [FLOORS-1:0] destination,
  output logic [FW-1:0]     cur_floor,
  output logic [1:0]        sim_state,
  output logic              tick
);
  import elevator_pkg::*;

  localparam int DW = $clog2(DOOR_TICKS + 1);

  sim_state_t        r_state;
  dir_t              r_last_dir;
  logic [FW-1:0]     r_cur;
  logic [FLOORS-1:0] r_dest;
  logic [DW-1:0]     r_door;
  logic              r_tick;
  logic              r_err;

  logic              w_tick;
  logic              w_acc, w_bad, w_ok, w_same;
  logic [FLOORS-1:0] w_req_mask, w_dest_req, w_dest_next;
  logic              w_up, w_dn, w_step, w_move, w_move_up, w_arrive, w_demo;
  logic              w_go_same, w_go_opp;
  logic [FW-1:0]     w_next_floor;

  tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (w_tick)
  );

  assign req_ready = rst;

  assign w_acc  = req_valid && req_ready;
  assign w_bad  = w_acc && (32'(req_floor) >= 32'(FLOORS));
  assign w_ok   = w_acc && !w_bad;
  // A request for the floor the car is parked at just (re)opens the doors.
  assign w_same = w_ok && (req_floor == r_cur) && (r_state == IDLE || r_state == DOORS);

  assign w_req_mask = (w_ok && !w_same) ? (FLOORS'(1) << req_floor) : '0;
  assign w_dest_req = r_dest | w_req_mask;

  assign w_up = pending_above(32'(r_dest), int'(r_cur));
  assign w_dn = pending_below(32'(r_dest), int'(r_cur));

  assign w_step       = w_tick && !w_same;
  assign w_move       = w_step && (r_state == UP || r_state == DOWN || (r_state == IDLE && (w_up || w_dn)));
  assign w_move_up    = (r_state == IDLE) ? w_up : (r_state == UP);
  assign w_next_floor = w_move_up ? r_cur + FW'(1) : r_cur - FW'(1);
  assign w_arrive     = w_move && w_dest_req[w_next_floor];
  assign w_demo       = w_step && (r_state == IDLE) && !w_up && !w_dn && demo_mode;

  assign w_go_same = (r_last_dir == DIR_UP) ? w_up : w_dn;
  assign w_go_opp  = (r_last_dir == DIR_UP) ? w_dn : w_up;

  always_comb begin
    w_dest_next = w_dest_req;
    if (w_demo) begin
      w_dest_next = (DEMO_PATTERN[FLOORS-1:0] & ~(FLOORS'(1) << r_cur)) | w_req_mask;
    end else if (w_arrive) begin
      w_dest_next = w_dest_req & ~(FLOORS'(1) << w_next_floor);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_last_dir <= DIR_UP;
      r_cur      <= '0;
      r_dest     <= '0;
      r_door     <= '0;
      r_tick     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_tick <= w_tick;
      r_err  <= w_bad;
      r_dest <= w_dest_next;
      if (w_same) begin
        r_state <= DOORS;
        r_door  <= DW'(DOOR_TICKS);
      end else if (w_step) begin
        case (r_state)
          IDLE, UP, DOWN: begin
            if (w_move) begin
              r_cur      <= w_next_floor;
              r_last_dir <= w_move_up ? DIR_UP : DIR_DOWN;
              if (w_arrive) begin
                r_state <= DOORS;
                r_door  <= DW'(DOOR_TICKS);
              end else begin
                r_state <= w_move_up ? UP : DOWN;
              end
            end
          end
          DOORS: begin
            if (r_door > DW'(1)) begin
              r_door <= r_door - DW'(1);
            end else begin
              // Departure tick only picks the direction; the car moves on the next tick.
              r_door <= '0;
              if (w_go_same) begin
                r_state <= (r_last_dir == DIR_UP) ? UP : DOWN;
              end else if (w_go_opp) begin
                r_state    <= (r_last_dir == DIR_UP) ? DOWN : UP;
                r_last_dir <= (r_last_dir == DIR_UP) ? DIR_DOWN : DIR_UP;
              end else begin
                r_state <= IDLE;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      assert (32'(r_cur) < 32'(FLOORS));
      if (w_move) assert (w_move_up ? (32'(r_cur) < 32'(FLOORS - 1)) : (r_cur != '0));
    end
  end

  assign destination = r_dest;
  assign cur_floor   = r_cur;
  assign sim_state   = r_state;
  assign tick        = r_tick;
  assign req_err     = r_err;

endmodule

// File: tb/tb_elevator_sim_driver.sv
// Scenario tasks plus a lockstep behavioural car model for randomized traffic.
module tb_elevator_sim_driver;

  localparam int TD = 4;
  localparam int DT = 2;
  localparam logic [1:0] S_IDLE = 2'b00, S_UP = 2'b01, S_DOWN = 2'b10, S_DOORS = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, demo_mode, req_valid;
  logic [2:0] req_floor;
  logic       req_ready, req_err, tick;
  logic [7:0] destination;
  logic [2:0] cur_floor;
  logic [1:0] sim_state;

  logic       req_valid6;
  logic [2:0] req_floor6;
  logic       req_ready6, req_err6, tick6;
  logic [5:0] dest6;
  logic [2:0] cur6;
  logic [1:0] state6;

  int n_checks = 0;
  int n_fail   = 0;

  elevator_sim_driver #(.FLOORS(8), .TICK_DIV(TD), .DOOR_TICKS(DT)) dut (
    .clk(clk), .rst(rst_n), .en(en), .demo_mode(demo_mode),
    .req_valid(req_valid), .req_floor(req_floor), .req_ready(req_ready), .req_err(req_err),
    .destination(destination), .cur_floor(cur_floor), .sim_state(sim_state), .tick(tick)
  );

  elevator_sim_driver #(.FLOORS(6), .TICK_DIV(TD), .DOOR_TICKS(DT)) dut6 (
    .clk(clk), .rst(rst_n), .en(1'b1), .demo_mode(1'b0),
    .req_valid(req_valid6), .req_floor(req_floor6), .req_ready(req_ready6), .req_err(req_err6),
    .destination(dest6), .cur_floor(cur6), .sim_state(state6), .tick(tick6)
  );

  // Behavioural car model: a floor number, a set of pending floors, and a mode.
  int         m_pcnt, m_door;
  logic [2:0] m_floor;
  logic [1:0] m_mode;
  logic [7:0] m_pend;
  logic       m_lastup, m_tick, m_err;
  logic       mt, ma, mb, msame, mmove;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pcnt = 0; m_door = 0; m_floor = 3'd0; m_mode = S_IDLE; m_pend = 8'h00;
      m_lastup = 1'b1; m_tick = 1'b0; m_err = 1'b0;
    end else begin
      mt = en && (m_pcnt == TD - 1);
      if (en) m_pcnt = mt ? 0 : m_pcnt + 1;
      ma = 1'b0; mb = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (m_pend[i] && i > int'(m_floor)) ma = 1'b1;
        if (m_pend[i] && i < int'(m_floor)) mb = 1'b1;
      end
      m_tick = mt;
      m_err  = req_valid && (int'(req_floor) >= 8);
      msame  = req_valid && (req_floor == m_floor) && (m_mode == S_IDLE || m_mode == S_DOORS);
      mmove  = 1'b0;
      if (msame) begin
        m_mode = S_DOORS; m_door = DT;
      end else begin
        if (req_valid) m_pend[req_floor] = 1'b1;
        if (mt) begin
          if (m_mode == S_IDLE) begin
            if (ma || mb) begin
              m_lastup = ma; m_mode = ma ? S_UP : S_DOWN; mmove = 1'b1;
            end else if (demo_mode) begin
              m_pend = 8'hAA;
              m_pend[m_floor] = 1'b0;
              if (req_valid) m_pend[req_floor] = 1'b1;
            end
          end else if (m_mode == S_UP || m_mode == S_DOWN) begin
            mmove = 1'b1;
          end else begin
            m_door = m_door - 1;
            if (m_door == 0) begin
              if (m_lastup ? ma : mb) m_mode = m_lastup ? S_UP : S_DOWN;
              else if (m_lastup ? mb : ma) begin
                m_lastup = !m_lastup; m_mode = m_lastup ? S_UP : S_DOWN;
              end else m_mode = S_IDLE;
            end
          end
        end
        if (mmove) begin
          m_floor = (m_mode == S_UP) ? m_floor + 3'd1 : m_floor - 3'd1;
          if (m_pend[m_floor]) begin
            m_pend[m_floor] = 1'b0; m_mode = S_DOORS; m_door = DT;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_tick(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (tick !== 1'b1 && n < 12);
    n_checks++;
    if (tick !== 1'b1) begin
      n_fail++; $display("FAIL %s_tick_timeout: got no tick in %0d cycles, required one", name, n);
    end
  endtask

  task automatic send_req(input int f);
    req_valid = 1'b1; req_floor = f[2:0];
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; demo_mode = 1'b0; req_valid = 1'b0; req_floor = 3'd0;
    req_valid6 = 1'b0; req_floor6 = 3'd0;
    repeat (3) @(posedge clk); #1;
    n_checks++;
    if ({destination, cur_floor, sim_state, tick, req_err, req_ready} !== 16'h0) begin
      n_fail++; $display("FAIL reset_outputs: got dest=%h floor=%0d state=%0d tick=%b err=%b ready=%b, required all zero",
                         destination, cur_floor, sim_state, tick, req_err, req_ready);
    end
    n_checks++;
    if (req_ready6 !== 1'b0 || dest6 !== 6'h0) begin
      n_fail++; $display("FAIL reset_dut6: got ready=%b dest=%h, required 0 and 00", req_ready6, dest6);
    end
    @(negedge clk) rst_n = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_reset: got %b required 1", req_ready);
    end
  endtask

  task automatic test_single_request();
    logic [2:0] exp_f [5] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3};
    logic [1:0] exp_s [5] = '{S_UP, S_UP, S_DOORS, S_DOORS, S_IDLE};
    send_req(3);
    n_checks++;
    if (destination !== 8'h08) begin
      n_fail++; $display("FAIL single_dest: got %h required 08", destination);
    end
    for (int k = 0; k < 5; k++) begin
      wait_tick("single");
      n_checks++;
      if (cur_floor !== exp_f[k] || sim_state !== exp_s[k]) begin
        n_fail++; $display("FAIL single_step%0d: got floor=%0d state=%0d required floor=%0d state=%0d",
                           k + 1, cur_floor, sim_state, exp_f[k], exp_s[k]);
      end
    end
    n_checks++;
    if (destination !== 8'h00) begin
      n_fail++; $display("FAIL single_dest_cleared: got %h required 00", destination);
    end
  endtask

  task automatic test_scan_order();
    logic [2:0] exp_f [11] = '{3'd4, 3'd5, 3'd6, 3'd6, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd2, 3'd2};
    logic [1:0] exp_s [11] = '{S_UP, S_UP, S_DOORS, S_DOORS, S_DOWN, S_DOWN, S_DOWN, S_DOWN,
                               S_DOORS, S_DOORS, S_IDLE};
    send_req(6);
    wait_tick("scan");
    n_checks++;
    if (cur_floor !== 3'd4 || sim_state !== S_UP) begin
      n_fail++; $display("FAIL scan_setup: got floor=%0d state=%0d required floor=4 state=1", cur_floor, sim_state);
    end
    send_req(2);
    n_checks++;
    if (destination !== 8'h44) begin
      n_fail++; $display("FAIL scan_pending: got %h required 44", destination);
    end
    for (int k = 1; k < 11; k++) begin
      wait_tick("scan");
      n_checks++;
      if (cur_floor !== exp_f[k] || sim_state !== exp_s[k]) begin
        n_fail++; $display("FAIL scan_step%0d: got floor=%0d state=%0d required floor=%0d state=%0d",
                           k + 1, cur_floor, sim_state, exp_f[k], exp_s[k]);
      end
      if (k == 2) begin
        n_checks++;
        if (destination !== 8'h04) begin
          n_fail++; $display("FAIL scan_after_6: got %h required 04", destination);
        end
      end
    end
  endtask

  task automatic test_same_floor();
    logic [1:0] exp_s [3] = '{S_DOORS, S_DOORS, S_IDLE};
    send_req(2);
    n_checks++;
    if (sim_state !== S_DOORS || destination !== 8'h00) begin
      n_fail++; $display("FAIL same_floor_open: got state=%0d dest=%h required state=3 dest=00", sim_state, destination);
    end
    wait_tick("same");
    send_req(2);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) wait_tick("same");
      n_checks++;
      if (sim_state !== exp_s[k] || cur_floor !== 3'd2) begin
        n_fail++; $display("FAIL same_floor_restart%0d: got state=%0d floor=%0d required state=%0d floor=2",
                           k, sim_state, cur_floor, exp_s[k]);
      end
    end
  endtask

  task automatic test_req_err();
    int bad [2] = '{7, 6};
    for (int k = 0; k < 2; k++) begin
      req_valid6 = 1'b1; req_floor6 = bad[k][2:0];
      @(posedge clk); #1;
      req_valid6 = 1'b0;
      n_checks++;
      if (req_err6 !== 1'b1 || dest6 !== 6'h00) begin
        n_fail++; $display("FAIL err_pulse_f%0d: got err=%b dest=%h required err=1 dest=00", bad[k], req_err6, dest6);
      end
      @(posedge clk); #1;
      n_checks++;
      if (req_err6 !== 1'b0) begin
        n_fail++; $display("FAIL err_one_cycle_f%0d: got err=%b required 0", bad[k], req_err6);
      end
    end
    req_valid6 = 1'b1; req_floor6 = 3'd5;
    @(posedge clk); #1;
    req_valid6 = 1'b0;
    n_checks++;
    if (req_err6 !== 1'b0 || dest6 !== 6'h20) begin
      n_fail++; $display("FAIL err_valid_f5: got err=%b dest=%h required err=0 dest=20", req_err6, dest6);
    end
  endtask

  task automatic test_demo();
    int served [$];
    logic [1:0] prev;
    int n;
    do_reset();
    demo_mode = 1'b1;
    wait_tick("demo");
    n_checks++;
    if (destination !== 8'hAA || sim_state !== S_IDLE || cur_floor !== 3'd0) begin
      n_fail++; $display("FAIL demo_load: got dest=%h state=%0d floor=%0d required dest=aa state=0 floor=0",
                         destination, sim_state, cur_floor);
    end
    prev = sim_state;
    n = 0;
    while (!(served.size() == 4 && sim_state == S_IDLE) && n < 30) begin
      wait_tick("demo");
      if (prev != S_DOORS && sim_state == S_DOORS) served.push_back(int'(cur_floor));
      prev = sim_state;
      n++;
    end
    n_checks++;
    if (served.size() != 4) begin
      n_fail++; $display("FAIL demo_serve_count: got %0d services required 4", served.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (served[k] != 2 * k + 1) begin
          n_fail++; $display("FAIL demo_order%0d: got floor %0d required %0d", k, served[k], 2 * k + 1);
        end
      end
    end
    wait_tick("demo");
    n_checks++;
    if (destination !== 8'h2A || cur_floor !== 3'd7) begin
      n_fail++; $display("FAIL demo_reload: got dest=%h floor=%0d required dest=2a floor=7", destination, cur_floor);
    end
    demo_mode = 1'b0;
  endtask

  task automatic test_reset_mid_motion();
    int n;
    do_reset();
    send_req(5);
    wait_tick("rstmid");
    wait_tick("rstmid");
    n_checks++;
    if (cur_floor !== 3'd2 || sim_state !== S_UP || destination !== 8'h20) begin
      n_fail++; $display("FAIL rstmid_setup: got floor=%0d state=%0d dest=%h required floor=2 state=1 dest=20",
                         cur_floor, sim_state, destination);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({destination, cur_floor, sim_state, tick, req_err, req_ready} !== 16'h0) begin
      n_fail++; $display("FAIL rstmid_async: got dest=%h floor=%0d state=%0d tick=%b err=%b ready=%b, required all zero",
                         destination, cur_floor, sim_state, tick, req_err, req_ready);
    end
    @(negedge clk) rst_n = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (tick !== 1'b1 && n < 10);
    n_checks++;
    if (n != TD) begin
      n_fail++; $display("FAIL rstmid_first_tick: got tick after %0d cycles required %0d", n, TD);
    end
    wait_tick("rstmid");
    n_checks++;
    if (sim_state !== S_IDLE || cur_floor !== 3'd0 || destination !== 8'h00) begin
      n_fail++; $display("FAIL rstmid_idle: got state=%0d floor=%0d dest=%h required state=0 floor=0 dest=00",
                         sim_state, cur_floor, destination);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0) demo_mode = ($urandom_range(0, 3) == 0);
      en        = ($urandom_range(0, 9) != 0);
      req_valid = ($urandom_range(0, 5) == 0);
      req_floor = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
      n_checks++;
      if (destination !== m_pend || cur_floor !== m_floor || sim_state !== m_mode ||
          tick !== m_tick || req_err !== m_err) begin
        n_fail++;
        $display("FAIL random_c%0d: got dest=%h floor=%0d state=%0d tick=%b err=%b required dest=%h floor=%0d state=%0d tick=%b err=%b",
                 c, destination, cur_floor, sim_state, tick, req_err, m_pend, m_floor, m_mode, m_tick, m_err);
      end
    end
    req_valid = 1'b0; en = 1'b1; demo_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_request();
    test_scan_order();
    test_same_floor();
    test_req_err();
    test_demo();
    test_reset_mid_motion();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/elevator_sim_driver.md
# elevator_sim_driver

Parametrised stimulus engine that replaces the fixed-count demo counter feeding `vgaController`. It drives `destination` and `sim_state` from a simulated elevator car rather than a free-running pattern. The block accepts floor requests over a valid/ready handshake and moves the car one floor per motion tick with SCAN (same-direction-first) ordering. It also has a self-running demo mode that reloads a parameter pattern whenever the car goes idle.

## Interface
- `FLOORS`, default 8: number of floors; must be ≥2; sets the width of `destination`.
- `TICK_DIV`, default 25_000_000: clock cycles per motion tick; must be ≥2.
- `DOOR_TICKS`, default 3: ticks the doors stay open; must be ≥1.
- `DEMO_PATTERN`, default 8'b1010_1010: request mask loaded in demo mode; the low `FLOORS` bits are used.
- `clk`  in  1  system clock (pixel-clock domain); one clock only.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  when low, freezes the prescaler and FSM; requests are still accepted.
- `demo_mode`  in  1  enables automatic pattern reload when idle.
- `req_valid`  in  1  a request is presented.
- `req_floor`  in  FW=$clog2(FLOORS)  requested floor.
- `req_ready`  out  1  high whenever not in reset.
- `req_err`  out  1  one-cycle pulse on an accepted request with `req_floor` ≥ FLOORS.
- `destination`  out  FLOORS  pending-request bitmask; bit i means floor i is pending.
- `cur_floor`  out  FW  current car floor.
- `sim_state`  out  2  00 IDLE, 01 UP, 10 DOWN, 11 DOORS.
- `tick`  out  1  one-cycle pulse on every motion tick.

## Operation
- Reset values: `destination`=0, `cur_floor`=0, `sim_state`=IDLE, `tick`=0, `req_err`=0, `req_ready`=0. Internally, the prescaler and door counter are 0 and `last_dir`=UP.
- Prescaler: counts 0..TICK_DIV-1 while `en` is high. `tick` pulses in the cycle the count wraps from TICK_DIV-1 to 0.
- Request acceptance (`req_valid`&&`req_ready`) is evaluated every cycle, independent of `tick`:
  - `req_floor` ≥ FLOORS: pulse `req_err`; no state change.
  - `req_floor`==`cur_floor` while in IDLE or DOORS: go to or stay in DOORS, reload the door counter to DOOR_TICKS, and leave the bit clear.
  - Otherwise: set `destination[req_floor]`. Setting an already-set bit is a no-op.
- FSM. All transitions below happen on `tick` only.
  - IDLE:
    - If any bit is pending, choose a direction: pending above → UP, otherwise DOWN. Move one floor in that direction on the same tick.
    - Else, if `demo_mode` is set, load DEMO_PATTERN with the `cur_floor` bit masked off. Do not move.
  - UP / DOWN: move `cur_floor` ±1.
  - Arrival rule, applied after every move: if the new floor's bit is pending, clear it, enter DOORS, and load the door counter with DOOR_TICKS. Otherwise keep moving.
  - DOORS: decrement the counter. When it reaches 0, pick the next state:
    - pending in `last_dir` → continue in `last_dir`;
    - else pending in the opposite direction → go that way;
    - else IDLE.
  - This departure tick does not move the car; movement starts on the next tick.
- `last_dir` updates on every entry to UP or DOWN.
- Simultaneous events:
  - A request for floor f in the same cycle as arrival at f: treated as served, so the bit ends clear.
  - A request in the same cycle as a demo load: OR-ed into the loaded pattern.
- `cur_floor` never leaves 0..FLOORS-1. UP at FLOORS-1 or DOWN at 0 is unreachable because direction is chosen only toward pending bits. Assert on it in simulation.

## Timing
- Request to `destination` bit visible: 1 cycle.
- Same-floor request in IDLE to `sim_state`=DOORS: 1 cycle.
- Idle at floor a, single request at floor b: `cur_floor` reaches b on tick |b−a| after acceptance, with DOORS entered in that same cycle. IDLE follows DOOR_TICKS ticks later.
- Outputs are registered; there are no combinational paths from inputs to outputs except `req_ready`, which is reset-only.
- Reset asserted mid-motion: every output returns to its reset value asynchronously. The first tick comes TICK_DIV cycles after release with `en` high.

## Structure
- Shared package `elevator_pkg`:
  - `sim_state_t` enum (IDLE=2'b00, UP=2'b01, DOWN=2'b10, DOORS=2'b11) and `dir_t`, shared with `vgaController`.
- Sub-module `tick_prescaler`: parameter `DIV`; ports `clk`, `rst`, `en`, `tick`. It is the parametrised successor of the divider.
- "Pending above/below" is a masked OR over `destination` relative to `cur_floor`. Implement it as a function in the package.

## Test plan
- Bench uses TICK_DIV=4, DOOR_TICKS=2, FLOORS=8.
- At floor 0, request 3: `destination`=8'h08 after 1 cycle; `cur_floor` steps 1,2,3 on ticks 1–3; DOORS with `destination`=0 at tick 3; IDLE at tick 5.
- At floor 4 moving UP with 2 and 6 pending: serves 6, then DOORS, then DOWN to 2. Visit order is 6,2.
- Request `req_floor`=0 while idle at 0: DOORS next cycle, `destination` stays 0. A repeat request during DOORS restarts the 2-tick door count.
- `req_floor`=9 (via a wide bench driver at FW=3, giving value 1 — instead run FLOORS=6, floor 7): `req_err` one-cycle pulse, `destination` unchanged.
- `demo_mode`=1, idle at 0: first tick loads 8'hAA; floors 1,3,5,7 are served in order, then reload.
- Assert `rst` during UP at floor 2 with 5 pending: all outputs go to reset values immediately. After release, the car stays IDLE at 0 and `destination`=0.
